// File: rtl/bnb_shift_pair.sv
`default_nettype none
// ============================================================================
//  Module      : bnb_shift_pair
//  Description : Two registered paths fed from one input. q1 is a single
//                flop, the collapsed chain with 1-cycle latency. q2 is a true
//                DEPTH-stage shift pipeline. A saturating fill counter flags
//                when real data has reached q2.
//  Revision    : 1.0 - initial release
// ============================================================================
module bnb_shift_pair #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [WIDTH-1:0]       d,
    output logic [WIDTH-1:0]       q1,
    output logic [WIDTH-1:0]       q2,
    output logic [WIDTH*DEPTH-1:0] taps,
    output logic                   q2_valid
);

    // The counter must be able to hold the value DEPTH itself.
    localparam int              c_CW       = $clog2(DEPTH + 1);
    localparam logic [c_CW-1:0] c_FILL_MAX = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_FILL_PRE = c_CW'(DEPTH - 1);

    logic [WIDTH-1:0] r_q1;
    logic [WIDTH-1:0] r_stage [DEPTH];
    logic [c_CW-1:0]  r_cnt;
    logic             r_valid;

    // Collapsed chain: every intermediate stage equals d, so one flop is enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q1 <= '0;
        end else if (en) begin
            r_q1 <= d;
        end
    end

    // True pipeline. Every stage loads the old value of its predecessor.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else if (en) begin
            r_stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    // Fill tracking. The counter saturates at DEPTH. The valid flag is
    // registered and rises on the edge where the counter reaches DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (en) begin
            if (r_cnt != c_FILL_MAX) begin
                r_cnt <= r_cnt + c_CW'(1);
            end
            r_valid <= r_valid | (r_cnt == c_FILL_PRE);
        end
    end

    // Flatten the stages onto taps, with stage 0 in the least significant bits.
    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_taps
            assign taps[g*WIDTH +: WIDTH] = r_stage[g];
        end
    endgenerate

    assign q1       = r_q1;
    assign q2       = r_stage[DEPTH-1];
    assign q2_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_bnb_shift_pair.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bnb_shift_pair
//  Description : Scoreboard bench for bnb_shift_pair. Instance A uses
//                WIDTH=1 and DEPTH=2. Instance B uses WIDTH=4 and DEPTH=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bnb_shift_pair;

    typedef struct {
        logic [31:0] q1;
        logic [31:0] q2;
        logic [31:0] taps;
        logic [31:0] valid;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_a = 1'b0;
    logic [0:0] d_a = '0;
    logic       en_b = 1'b0;
    logic [3:0] d_b = '0;

    logic [0:0] q1_a, q2_a;
    logic [1:0] taps_a;
    logic       v_a;
    logic [3:0] q1_b, q2_b, taps_b;
    logic       v_b;

    int n_vec = 0;
    int n_err = 0;

    exp_t sb_a[$];
    exp_t sb_b[$];

    // Reference state for instance A
    logic m_q1, m_s0, m_s1;
    int   m_cnt;
    // Reference state for instance B
    logic [3:0] mb_q1;
    int         mb_cnt;

    always #100 clk = ~clk;

    bnb_shift_pair #(.WIDTH(1), .DEPTH(2)) u_dut_a (
        .clk(clk), .rst(rst), .en(en_a), .d(d_a),
        .q1(q1_a), .q2(q2_a), .taps(taps_a), .q2_valid(v_a)
    );

    bnb_shift_pair #(.WIDTH(4), .DEPTH(1)) u_dut_b (
        .clk(clk), .rst(rst), .en(en_b), .d(d_b),
        .q1(q1_b), .q2(q2_b), .taps(taps_b), .q2_valid(v_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the A reference model by one edge and queue the expected outputs.
    task automatic model_a(input logic r, input logic e, input logic dv);
        exp_t x;
        if (r) begin
            m_q1 = 0; m_s0 = 0; m_s1 = 0; m_cnt = 0;
        end else if (e) begin
            m_s1 = m_s0;
            m_s0 = dv;
            m_q1 = dv;
            if (m_cnt < 2) m_cnt++;
        end
        x.q1    = 32'(m_q1);
        x.q2    = 32'(m_s1);
        x.taps  = 32'({m_s1, m_s0});
        x.valid = 32'(m_cnt == 2);
        sb_a.push_back(x);
    endtask

    task automatic compare_a(input string tag);
        exp_t x;
        if (sb_a.size() == 0) begin
            check_eq({tag, ".sb_empty"}, 32'd1, 32'd0);
            return;
        end
        x = sb_a.pop_front();
        check_eq({tag, ".q1"},    32'(q1_a),   x.q1);
        check_eq({tag, ".q2"},    32'(q2_a),   x.q2);
        check_eq({tag, ".taps"},  32'(taps_a), x.taps);
        check_eq({tag, ".valid"}, 32'(v_a),    x.valid);
    endtask

    task automatic step_a(input string tag, input logic r, input logic e, input logic dv);
        rst = r; en_a = e; d_a = dv;
        model_a(r, e, dv);
        @(posedge clk); #1;
        compare_a(tag);
    endtask

    // d pulses high and low again entirely between two edges, so the edge captures 0.
    task automatic step_glitch(input string tag);
        rst = 0; en_a = 1; d_a = 0;
        model_a(0, 1, 0);
        #40 d_a = 1;
        #40 d_a = 0;
        @(posedge clk); #1;
        compare_a(tag);
    endtask

    task automatic step_b(input string tag, input logic e, input logic [3:0] dv);
        exp_t x;
        en_b = e; d_b = dv;
        if (e) begin
            mb_q1 = dv;
            if (mb_cnt < 1) mb_cnt++;
        end
        x.q1 = 32'(mb_q1); x.q2 = 32'(mb_q1); x.taps = 32'(mb_q1);
        x.valid = 32'(mb_cnt == 1);
        sb_b.push_back(x);
        @(posedge clk); #1;
        x = sb_b.pop_front();
        check_eq({tag, ".q1"},    32'(q1_b),   x.q1);
        check_eq({tag, ".q2"},    32'(q2_b),   x.q2);
        check_eq({tag, ".taps"},  32'(taps_b), x.taps);
        check_eq({tag, ".valid"}, 32'(v_b),    x.valid);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic lat_seq [5];
        m_q1 = 0; m_s0 = 0; m_s1 = 0; m_cnt = 0;
        mb_q1 = '0; mb_cnt = 0;
        lat_seq = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset has priority over en. The edge after release captures d=1.
        step_a("rst0", 1, 1, 1);
        step_a("rst1", 1, 1, 1);
        step_a("first", 0, 1, 1);

        // Latency comparison, starting from an empty pipeline
        step_a("lat_rst", 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step_a($sformatf("lat%0d", i), 0, 1, lat_seq[i]);
        end

        // A glitch between edges is not captured
        step_a("pre_glitch", 0, 1, 1);
        step_glitch("glitch");

        // Hold: set taps=01 and q1=1, then hold for three edges while d toggles
        step_a("hold_set0", 0, 1, 0);
        step_a("hold_set1", 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            step_a($sformatf("hold%0d", i), 0, 0, logic'(i[0] ^ 1'b1));
        end
        step_a("hold_resume", 0, 1, 0);

        // Reset in mid-stream, then refill
        step_a("full0", 0, 1, 1);
        step_a("full1", 0, 1, 1);
        step_a("mid_rst", 1, 1, 1);
        step_a("refill0", 0, 1, 1);
        step_a("refill1", 0, 1, 1);

        // DEPTH=1 build: q2 follows q1 exactly
        rst = 0; en_a = 0;
        for (int i = 0; i < 20; i++) begin
            step_b($sformatf("b%0d", i), 1, 4'($urandom_range(0, 15)));
        end
        step_b("b_hold", 0, 4'hA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
